audio_receive: RTL

AUDIO_RECEIVE -- requirements
Module: audio_receive

---
 rtl/audio_receive.sv | 122 ++++++++++++
 1 files changed

// File: rtl/audio_receive.sv
// I2S-style ADC receiver for the WM8978: deserialises left/right words on aud_bclk
// and queues stereo pairs in a 4-deep first-word-fall-through FIFO.
module audio_receive #(
   parameter logic [5:0] WL = 6'd32
) (
   input  logic        aud_bclk,
   input  logic        rst_n,
   input  logic        aud_lrc,
   input  logic        aud_adcdat,
   output logic [31:0] adc_data_l,
   output logic [31:0] adc_data_r,
   output logic        adc_valid,
   input  logic        adc_ready,
   output logic        rx_done,
   output logic [2:0]  fifo_cnt,
   output logic        overflow
);

   localparam int W = int'(WL);

   logic          aud_lrc_d0;
   logic          synced;
   logic [5:0]    rx_cnt;
   logic [5:0]    rx_cnt_d;
   logic [W-1:0]  shift;
   logic [W-1:0]  shift_d;
   logic [W-1:0]  word_bits;
   logic [31:0]   word32;
   logic [31:0]   left_hold;
   logic          l_vld;
   logic [63:0]   fifo_mem [4];
   logic [1:0]    wr_ptr;
   logic [1:0]    rd_ptr;

   logic lrc_edge;
   logic word_full;
   logic word_lsb;
   logic commit;
   logic push_req;
   logic push;
   logic pop;
   logic full;

   assign lrc_edge  = aud_lrc ^ aud_lrc_d0;
   assign word_full = (rx_cnt == WL);
   assign word_lsb  = (rx_cnt == WL - 6'd1);
   assign commit    = lrc_edge & synced & (word_full | word_lsb);
   // Committed channel is the one that just ended (aud_lrc_d0 = 1 means right).
   assign push_req  = commit & aud_lrc_d0 & l_vld;
   assign full      = (fifo_cnt == 3'd4);
   assign pop       = adc_valid & adc_ready;
   assign push      = push_req & (~full | pop);

   assign adc_valid = (fifo_cnt != 3'd0);
   assign adc_data_l = fifo_mem[rd_ptr][63:32];
   assign adc_data_r = fifo_mem[rd_ptr][31:0];

   always_comb begin
      rx_cnt_d = rx_cnt;
      shift_d  = shift;
      if (lrc_edge) begin
         rx_cnt_d = 6'd0;
      end else if (rx_cnt < WL) begin
         rx_cnt_d = rx_cnt + 6'd1;
         for (int i = 0; i < W; i++) begin
            if (rx_cnt == 6'(W - 1 - i)) shift_d[i] = aud_adcdat;
         end
      end
   end

   // When the LRC change lands on the LSB slot, that bit is still on the wire this cycle.
   always_comb begin
      word_bits = word_full ? shift : {shift[W-1:1], aud_adcdat};
      word32 = '0;
      word32[W-1:0] = word_bits;
   end

   always_ff @(posedge aud_bclk) begin
      if (!rst_n) begin
         aud_lrc_d0 <= 1'b0;
         synced     <= 1'b0;
         rx_cnt     <= 6'd0;
         shift      <= '0;
         left_hold  <= '0;
         l_vld      <= 1'b0;
         wr_ptr     <= 2'd0;
         rd_ptr     <= 2'd0;
         fifo_cnt   <= 3'd0;
         rx_done    <= 1'b0;
         overflow   <= 1'b0;
         for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
      end else begin
         aud_lrc_d0 <= aud_lrc;
         if (lrc_edge) synced <= 1'b1;
         rx_cnt  <= rx_cnt_d;
         shift   <= shift_d;
         rx_done <= commit;

         if (commit && !aud_lrc_d0) begin
            left_hold <= word32;
            l_vld     <= 1'b1;
         end else if (push_req) begin
            l_vld <= 1'b0;
         end

         if (push) begin
            fifo_mem[wr_ptr] <= {left_hold, word32};
            wr_ptr <= wr_ptr + 2'd1;
         end
         if (pop) rd_ptr <= rd_ptr + 2'd1;

         if (push && !pop) begin
            fifo_cnt <= fifo_cnt + 3'd1;
         end else if (pop && !push) begin
            fifo_cnt <= fifo_cnt - 3'd1;
         end

         if (push_req && full && !pop) overflow <= 1'b1;
      end
   end

endmodule
